reg_scoreboard: RTL

- Hazard scheduler for the 16-entry register file.
- Tracks in-flight writes per architectural register using small pending counters.
- Raises `stall` to the decode/issue stage when an issuing instruction reads a register with an outstanding write (RAW), or when the destination's counter is saturated.
- Sits between decode (issue side) and the writeback stage; the writeback side mirrors the register file's `WB_en`/`WB_dest`.

---
 rtl/reg_scoreboard_pkg.sv | 7 +
 rtl/reg_scoreboard_pending_cnt.sv | 31 +++
 rtl/reg_scoreboard.sv | 90 +++++++++
 3 files changed

// File: rtl/reg_scoreboard_pkg.sv
// Shared settings for the register scoreboard: register file geometry and counter widths.
package reg_scoreboard_pkg;
    localparam int unsigned REG_FILE_SIZE  = 16;
    localparam int unsigned REG_FILE_DEPTH = 4;
    localparam int unsigned SB_CNT_W       = 2;
    localparam int unsigned SB_TOT_W       = 6;
endpackage

// File: rtl/reg_scoreboard_pending_cnt.sv
// sb_pending_cnt: saturating up/down pending-write counter with clear, zero flag and underflow pulse.
module sb_pending_cnt #(
    parameter int unsigned CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             dec,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt,
    output logic             zero,
    output logic             underflow_c
);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    assign zero        = (cnt == '0);
    // A lone decrement with nothing pending is an error; a matched inc/dec nets out.
    assign underflow_c = ~clr & dec & ~inc & zero;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && !dec && cnt != CNT_MAX) begin
            cnt <= cnt + CNT_W'(1);
        end else if (dec && !inc && !zero) begin
            cnt <= cnt - CNT_W'(1);
        end
    end
endmodule

// File: rtl/reg_scoreboard.sv
// RAW / saturation hazard scheduler over the register file's pending writes.
// Optional SB_WB_BYPASS_EN: same-cycle writeback clears the hazard (register file writes on negedge).
module reg_scoreboard
    import reg_scoreboard_pkg::*;
#(
    parameter int unsigned NUM_REGS = REG_FILE_SIZE,
    parameter int unsigned IDX_W    = REG_FILE_DEPTH,
    parameter int unsigned CNT_W    = SB_CNT_W,
    parameter int unsigned TOT_W    = SB_TOT_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                issue_valid,
    input  logic [IDX_W-1:0]    issue_src1,
    input  logic                issue_src1_used,
    input  logic [IDX_W-1:0]    issue_src2,
    input  logic                issue_src2_used,
    input  logic                issue_wb,
    input  logic [IDX_W-1:0]    issue_dest,
    input  logic                flush,
    input  logic                WB_en,
    input  logic [IDX_W-1:0]    WB_dest,
    output logic                stall,
    output logic                issue_fire,
    output logic [NUM_REGS-1:0] busy_mask,
    output logic [TOT_W-1:0]    inflight,
    output logic                wb_underflow
);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0]    cnt [NUM_REGS];
    logic [NUM_REGS-1:0] zero_vec;
    logic [NUM_REGS-1:0] uf_vec;
    logic                raw1, raw2, sat;
    logic                inc_any, dec_cnt;

    // One pending counter per architectural register.
    for (genvar r = 0; r < NUM_REGS; r++) begin : g_cnt
        sb_pending_cnt #(.CNT_W(CNT_W)) u_cnt (
            .clk         (clk),
            .rst         (rst),
            .inc         (issue_fire & issue_wb & (issue_dest == IDX_W'(r))),
            .dec         (WB_en & (WB_dest == IDX_W'(r))),
            .clr         (flush),
            .cnt         (cnt[r]),
            .zero        (zero_vec[r]),
            .underflow_c (uf_vec[r])
        );
    end

    assign busy_mask = ~zero_vec;

    // Hazard detection and issue handshake.
    always_comb begin
        raw1       = issue_src1_used & (cnt[issue_src1] != '0);
        raw2       = issue_src2_used & (cnt[issue_src2] != '0);
        sat        = issue_wb & (cnt[issue_dest] == CNT_MAX);
        stall      = 1'b0;
        issue_fire = issue_valid;
`ifdef SB_WB_BYPASS_EN
        if (WB_en && WB_dest == issue_src1 && cnt[issue_src1] == CNT_W'(1)) raw1 = 1'b0;
        if (WB_en && WB_dest == issue_src2 && cnt[issue_src2] == CNT_W'(1)) raw2 = 1'b0;
        if (WB_en && WB_dest == issue_dest) sat = 1'b0;
`endif
        if (rst) begin
            stall      = issue_valid & ~flush & (raw1 | raw2 | sat);
            issue_fire = issue_valid & ~flush & ~stall;
        end
    end

    assign inc_any = issue_fire & issue_wb;
    assign dec_cnt = WB_en & ~(|uf_vec);

    // Total in-flight count and sticky underflow flag; flush leaves the flag alone.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inflight     <= '0;
            wb_underflow <= 1'b0;
        end else begin
            if (|uf_vec) wb_underflow <= 1'b1;
            if (flush) begin
                inflight <= '0;
            end else if (inc_any && !dec_cnt) begin
                inflight <= inflight + TOT_W'(1);
            end else if (!inc_any && dec_cnt) begin
                inflight <= inflight - TOT_W'(1);
            end
        end
    end
endmodule
